sda_kernel_irq_ctrl: RTL and testbench



---
 rtl/sda_kernel_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_sda_kernel_irq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_kernel_irq_ctrl.sv
// SDAccel-style GIE/IER/ISR interrupt controller with a req/ack register port.
// Optional saturating done-event counter on CNT enabled by SDA_KERNEL_IRQ_DONE_COUNT_EN.
module sda_kernel_irq_ctrl #(
    parameter int NUM_IRQ     = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               reg_req,
    output logic               reg_ack,
    input  logic               reg_write_en,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic [NUM_IRQ-1:0] irq_event,
    output logic               ap_interrupt
);

    // state   | meaning
    // IDLE    | waiting for reg_req; access performed on the accepting edge
    // ACK     | reg_ack high for one cycle, reg_rdata valid
    // RELEASE | waiting for reg_req to drop before accepting again
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_GIE = 2'd0;
    localparam logic [1:0] ADDR_IER = 2'd1;
    localparam logic [1:0] ADDR_ISR = 2'd2;
    localparam logic [1:0] ADDR_CNT = 2'd3;

    state_t               state_q;
    logic                 reg_ack_q;
    logic [31:0]          reg_rdata_q;
    logic                 irq_q;
    logic                 gie_q, gie_d;
    logic [NUM_IRQ-1:0]   ier_q, ier_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [NUM_IRQ-1:0]   toggle_mask;
    logic                 access;
    logic                 wr;
    logic [31:0]          cnt_rd;
    logic [31:0]          rd_val;
    logic                 unused_wdata;

    assign access = (state_q == ST_IDLE) && reg_req;
    assign wr     = access && reg_write_en;

    assign toggle_mask = (wr && reg_addr == ADDR_ISR) ? reg_wdata[NUM_IRQ-1:0] : '0;
    assign gie_d       = (wr && reg_addr == ADDR_GIE) ? reg_wdata[0] : gie_q;
    assign ier_d       = (wr && reg_addr == ADDR_IER) ? reg_wdata[NUM_IRQ-1:0] : ier_q;
    // A same-cycle event overrides a toggle that would clear the bit.
    assign isr_d       = (isr_q ^ toggle_mask) | irq_event;

    assign unused_wdata = ^reg_wdata;

`ifdef SDA_KERNEL_IRQ_DONE_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr && reg_addr == ADDR_CNT)
            cnt_d = '0;
        else if (irq_event[0] && (cnt_q != '1))
            cnt_d = cnt_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign cnt_rd = 32'(cnt_q);
`else
    logic [COUNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
    assign cnt_rd     = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            ADDR_GIE: rd_val = 32'(gie_q);
            ADDR_IER: rd_val = 32'(ier_q);
            ADDR_ISR: rd_val = 32'(isr_q);
            ADDR_CNT: rd_val = cnt_rd;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            reg_ack_q   <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            reg_ack_q   <= 1'b0;
            reg_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (reg_req) begin
                        state_q     <= ST_ACK;
                        reg_ack_q   <= 1'b1;
                        reg_rdata_q <= reg_write_en ? 32'd0 : rd_val;
                    end
                end
                ST_ACK:     state_q <= ST_RELEASE;
                ST_RELEASE: if (!reg_req) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie_q <= 1'b0;
            ier_q <= '0;
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            gie_q <= gie_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= gie_q & (|(isr_q & ier_q));
        end
    end

    assign reg_ack      = reg_ack_q;
    assign reg_rdata    = reg_rdata_q;
    assign ap_interrupt = irq_q;

endmodule

// File: tb/tb_sda_kernel_irq_ctrl.sv
// Bench for sda_kernel_irq_ctrl: directed scenarios plus random traffic against a
// cycle-level register model; honours SDA_KERNEL_IRQ_DONE_COUNT_EN like the design.
module tb_sda_kernel_irq_ctrl;

    localparam int NUM_IRQ = 2;
    localparam int CW      = 2;
    localparam int MASK    = (1 << NUM_IRQ) - 1;
    localparam int CMAX    = (1 << CW) - 1;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               reg_req;
    logic               reg_ack;
    logic               reg_write_en;
    logic [1:0]         reg_addr;
    logic [31:0]        reg_wdata;
    logic [31:0]        reg_rdata;
    logic [NUM_IRQ-1:0] irq_event;
    logic               ap_interrupt;

    sda_kernel_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .COUNT_WIDTH(CW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .reg_req     (reg_req),
        .reg_ack     (reg_ack),
        .reg_write_en(reg_write_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .irq_event   (irq_event),
        .ap_interrupt(ap_interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers holding the architectural register values.
    int unsigned m_gie, m_ier, m_isr, m_cnt;
    int unsigned exp_int, exp_ack, exp_rdata;
    bit          busy;
    int          since_acc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned model_read(input int unsigned addr);
        case (addr)
            0: return m_gie;
            1: return m_ier;
            2: return m_isr;
`ifdef SDA_KERNEL_IRQ_DONE_COUNT_EN
            3: return m_cnt;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_gie = 0; m_ier = 0; m_isr = 0; m_cnt = 0;
        exp_int = 0; exp_ack = 0; exp_rdata = 0;
        busy = 0; since_acc = 0;
    endtask

    // One clock edge of the programming model, using the inputs driven before the edge.
    task automatic model_tick();
        int unsigned ev, toggle, int_next;
        bit acc, wr;
        ev       = int'(irq_event);
        int_next = (m_gie != 0 && (m_isr & m_ier) != 0) ? 1 : 0;
        acc      = reg_req && !busy;
        if (busy) begin
            since_acc++;
            if (!reg_req && since_acc >= 2) busy = 0;
        end
        if (acc) begin
            busy = 1;
            since_acc = 0;
        end
        wr        = acc && reg_write_en;
        exp_ack   = acc ? 1 : 0;
        exp_rdata = (acc && !reg_write_en) ? model_read(int'(reg_addr)) : 0;
        toggle    = (wr && reg_addr == 2) ? (reg_wdata & MASK) : 0;
        if (wr && reg_addr == 3) m_cnt = 0;
        else if ((ev & 1) != 0 && m_cnt < CMAX) m_cnt++;
        m_isr = (m_isr ^ toggle) | ev;
        if (wr && reg_addr == 0) m_gie = reg_wdata[0];
        if (wr && reg_addr == 1) m_ier = reg_wdata & MASK;
        exp_int = int_next;
    endtask

    task automatic cycle();
        @(posedge ap_clk);
        model_tick();
        #1;
        check_val("ack", 32'(reg_ack), exp_ack);
        check_val("rdata", reg_rdata, exp_rdata);
        check_val("irq", 32'(ap_interrupt), exp_int);
    endtask

    task automatic access(input bit we, input logic [1:0] addr, input logic [31:0] wdata,
                          input logic [NUM_IRQ-1:0] ev, output logic [31:0] rd);
        reg_req = 1; reg_write_en = we; reg_addr = addr; reg_wdata = wdata;
        irq_event = ev;
        cycle();
        irq_event = '0;
        rd = reg_rdata;
        reg_req = 0;
        cycle();
        cycle();
    endtask

    logic [31:0] rd;
    int          acks;
    logic [NUM_IRQ-1:0] ev_r;

    initial begin
        ap_rst_n = 0; reg_req = 0; reg_write_en = 0; reg_addr = '0; reg_wdata = '0;
        irq_event = '0;
        model_reset();
        repeat (2) @(posedge ap_clk);
        #2;
        check_val("rst_ack", 32'(reg_ack), 0);
        check_val("rst_rdata", reg_rdata, 0);
        check_val("rst_irq", 32'(ap_interrupt), 0);
        @(negedge ap_clk) ap_rst_n = 1;

        for (int a = 0; a < 4; a++) begin
            access(0, 2'(a), 0, '0, rd);
            check_val("rst_read", rd, 0);
        end

        // Basic interrupt path
        access(1, 2'd0, 32'h1, '0, rd);
        access(1, 2'd1, 32'h1, '0, rd);
        irq_event = 2'b01;
        cycle();
        irq_event = '0;
        check_val("basic_n1", 32'(ap_interrupt), 0);
        cycle();
        check_val("basic_n2", 32'(ap_interrupt), 1);
        access(0, 2'd2, 0, '0, rd);
        check_val("basic_isr", rd, 32'h1);
        access(1, 2'd2, 32'h1, '0, rd);
        check_val("basic_clr", 32'(ap_interrupt), 0);

        // Masking
        access(1, 2'd1, 32'h2, '0, rd);
        irq_event = 2'b01;
        cycle();
        irq_event = '0;
        cycle(); cycle();
        check_val("mask_irq", 32'(ap_interrupt), 0);
        access(0, 2'd2, 0, '0, rd);
        check_val("mask_isr", rd, 32'h1);
        access(1, 2'd1, 32'h3, '0, rd);
        check_val("unmask_irq", 32'(ap_interrupt), 1);

        // Event and toggle-write on the same edge
        access(1, 2'd2, 32'h1, 2'b01, rd);
        check_val("coll_irq", 32'(ap_interrupt), 1);
        access(0, 2'd2, 0, '0, rd);
        check_val("coll_isr", rd, 32'h1);

        // Held request gets exactly one ack
        acks = 0;
        reg_req = 1; reg_write_en = 1; reg_addr = 2'd0; reg_wdata = 32'h1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (reg_ack) acks++;
        end
        reg_req = 0;
        cycle(); cycle();
        check_val("hold_acks", 32'(acks), 1);

        // Done counter
        access(1, 2'd3, 32'h0, '0, rd);
        for (int i = 0; i < 3; i++) begin
            irq_event = 2'b01; cycle(); irq_event = '0; cycle();
        end
        access(0, 2'd3, 0, '0, rd);
`ifdef SDA_KERNEL_IRQ_DONE_COUNT_EN
        check_val("cnt3", rd, 32'd3);
`else
        check_val("cnt3", rd, 32'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            irq_event = 2'b01; cycle(); irq_event = '0;
        end
        access(0, 2'd3, 0, '0, rd);
`ifdef SDA_KERNEL_IRQ_DONE_COUNT_EN
        check_val("cnt_sat", rd, 32'd3);
`else
        check_val("cnt_sat", rd, 32'd0);
`endif
        access(1, 2'd3, 32'hFFFF_FFFF, '0, rd);
        access(0, 2'd3, 0, '0, rd);
        check_val("cnt_clr", rd, 32'd0);

        // Asynchronous reset while in ACK with interrupt asserted
        access(1, 2'd0, 32'h1, 2'b01, rd);
        reg_req = 1; reg_write_en = 0; reg_addr = 2'd2;
        cycle();
        #3 ap_rst_n = 0;
        #1;
        check_val("arst_ack", 32'(reg_ack), 0);
        check_val("arst_rdata", reg_rdata, 0);
        check_val("arst_irq", 32'(ap_interrupt), 0);
        model_reset();
        @(posedge ap_clk);
        @(negedge ap_clk) ap_rst_n = 1;
        cycle();
        check_val("arst_reacc", 32'(reg_ack), 1);
        reg_req = 0;
        cycle(); cycle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < NUM_IRQ; b++) ev_r[b] = ($urandom_range(0, 3) == 0);
            irq_event = ev_r;
            if (reg_req) begin
                if ($urandom_range(0, 1) == 1) reg_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                reg_req      = 1;
                reg_write_en = $urandom_range(0, 1) == 1;
                reg_addr     = 2'($urandom_range(0, 3));
                reg_wdata    = $urandom;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
